// File: rtl/clk_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl_pkg
// Description : Shared types and helpers for the clock divider ratio
//               reconfiguration controller.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_APPLY  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESP   = 3'd4
  } clk_div_ctrl_state_e;

  // Width needed by the shared timer to hold the larger of the two reload values
  function automatic int unsigned timer_width(input int unsigned drain_cycles,
                                              input int unsigned settle_cycles);
    int unsigned max_cycles;
    max_cycles = (drain_cycles > settle_cycles) ? drain_cycles : settle_cycles;
    return ($clog2(max_cycles + 1) > 0) ? $clog2(max_cycles + 1) : 1;
  endfunction

endpackage : clk_div_ctrl_pkg
`default_nettype wire

// File: rtl/clk_div_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl_timer
// Description : Loadable saturating down-counter used for both the drain and
//               settle intervals of the ratio reconfiguration sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Load takes priority; otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : clk_div_ctrl_timer
`default_nettype wire

// File: rtl/clk_div_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_reconfig_ctrl
// Description : Sequences run-time division ratio changes: validates a
//               request, gates the divided clock, drains, applies the new
//               ratio, lets the divider settle, reopens the gate, responds.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_reconfig_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter  int unsigned MAX_DIV_BY    = 3,
  parameter  int unsigned RESET_DIV     = 1,
  parameter  int unsigned DRAIN_CYCLES  = 4,
  parameter  int unsigned SETTLE_CYCLES = 2 * MAX_DIV_BY,
  localparam int unsigned W             = (MAX_DIV_BY > 1) ? $clog2(MAX_DIV_BY) : 1
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [W-1:0] req_div_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         rsp_err_o,
  output logic [W-1:0] div_conf_o,
  output logic         clk_gate_en_o,
  output logic         busy_o
);

  localparam int unsigned  TW          = timer_width(DRAIN_CYCLES, SETTLE_CYCLES);
  localparam logic [W-1:0] MAX_DIV_W   = W'(MAX_DIV_BY);
  localparam logic [W-1:0] RESET_DIV_W = W'(RESET_DIV);
  localparam logic [TW-1:0] DRAIN_LOAD  = TW'(DRAIN_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  if ((RESET_DIV < 1) || (RESET_DIV > MAX_DIV_BY)) begin : g_chk_reset_div
    $error("RESET_DIV must lie in 1..MAX_DIV_BY");
  end
  if (DRAIN_CYCLES < 1) begin : g_chk_drain
    $error("DRAIN_CYCLES must be at least 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_chk_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  clk_div_ctrl_state_e state_d, state_q;
  logic [W-1:0]        div_conf_d, div_conf_q;
  logic [W-1:0]        req_div_d, req_div_q;
  logic                gate_en_d, gate_en_q;
  logic                rsp_valid_d, rsp_valid_q;
  logic                rsp_err_d, rsp_err_q;
  logic                req_ready_d, req_ready_q;
  logic                busy_d, busy_q;
  logic                tmr_load;
  logic [TW-1:0]       tmr_value;
  logic                tmr_zero;

  clk_div_ctrl_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk     (clk_in),
    .rst     (rst),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .zero_o  (tmr_zero)
  );

  // Next-state and next-output logic; all outputs are registered from these
  always_comb begin
    state_d     = state_q;
    div_conf_d  = div_conf_q;
    req_div_d   = req_div_q;
    gate_en_d   = gate_en_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          req_div_d = req_div_i;
          if ((req_div_i == '0) || (req_div_i > MAX_DIV_W)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_div_i == div_conf_q) begin
            // Ratio already in effect: acknowledge without disturbing the clock
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
          end else begin
            state_d   = ST_DRAIN;
            gate_en_d = 1'b0;
            tmr_load  = 1'b1;
            tmr_value = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (tmr_zero) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        div_conf_d = req_div_q;
        tmr_load   = 1'b1;
        tmr_value  = SETTLE_LOAD;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d     = ST_RESP;
          gate_en_d   = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready only ever asserted from a registered IDLE, so a response
    // handshake cycle can never double as an accept cycle
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Single state/output register bank with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_conf_q  <= RESET_DIV_W;
      req_div_q   <= '0;
      gate_en_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_conf_q  <= div_conf_d;
      req_div_q   <= req_div_d;
      gate_en_q   <= gate_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign div_conf_o    = div_conf_q;
  assign clk_gate_en_o = gate_en_q;
  assign busy_o        = busy_q;

endmodule : clk_div_reconfig_ctrl
`default_nettype wire

// File: tb/tb_clk_div_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_reconfig_ctrl
// Description : Self-checking bench for clk_div_reconfig_ctrl with default
//               parameters (MAX_DIV_BY=3, DRAIN=4, SETTLE=6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_reconfig_ctrl;

  localparam int DRAIN  = 4;
  localparam int SETTLE = 6;
  localparam int MAXDIV = 3;

  typedef struct packed {
    logic       err;
    logic [1:0] div;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [1:0] req_div_i = '0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic       rsp_err_o;
  logic [1:0] div_conf_o;
  logic       clk_gate_en_o;
  logic       busy_o;

  int         n_total = 0;
  int         n_bad   = 0;
  exp_t       exp_q[$];
  logic [1:0] model_div = 2'd1;

  always #5 clk_in = ~clk_in;

  clk_div_reconfig_ctrl dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_div_i     (req_div_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_err_o     (rsp_err_o),
    .div_conf_o    (div_conf_o),
    .clk_gate_en_o (clk_gate_en_o),
    .busy_o        (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive a request from a negedge; return at the negedge after the accept edge
  task automatic accept(input logic [1:0] d);
    exp_t e;
    int   guard;
    guard = 0;
    while (!req_ready_o && guard < 100) begin
      @(negedge clk_in);
      guard++;
    end
    chk("ready_wait", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_div_i   = d;
    e.err = (d == 2'd0) || (int'(d) > MAXDIV);
    if (!e.err) model_div = d;
    e.div = model_div;
    exp_q.push_back(e);
    @(posedge clk_in);
    @(negedge clk_in);
    req_valid_i = 1'b0;
  endtask

  // Wait for a response, optionally stall it, then complete the handshake
  task automatic collect_rsp(input int hold);
    exp_t e;
    int   guard;
    logic err0;
    guard = 0;
    while (!rsp_valid_o && guard < 100) begin
      @(negedge clk_in);
      guard++;
    end
    chk("rsp_wait", rsp_valid_o, 1);
    err0 = rsp_err_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_in);
      chk("rsp_held", rsp_valid_o, 1);
      chk("rsp_err_stable", rsp_err_o, err0);
      chk("ready_low_in_rsp", req_ready_o, 0);
    end
    rsp_ready_i = 1'b1;
    chk("sb_nonempty", exp_q.size(), (exp_q.size() == 0) ? 1 : exp_q.size());
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp_err", rsp_err_o, e.err);
      chk("rsp_div_conf", div_conf_o, e.div);
    end
    chk("rsp_gate_open", clk_gate_en_o, 1);
    @(posedge clk_in);
    @(negedge clk_in);
    rsp_ready_i = 1'b0;
    chk("idle_ready", req_ready_o, 1);
    chk("idle_busy", busy_o, 0);
    chk("idle_rsp_valid", rsp_valid_o, 0);
  endtask

  initial begin
    // Test 1: reset values
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    chk("rst_div", div_conf_o, 1);
    chk("rst_gate", clk_gate_en_o, 1);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    @(negedge clk_in);

    // Test 2: valid change 1 -> 3 with full timing profile
    accept(2'd3);
    for (int k = 1; k <= DRAIN + SETTLE + 2; k++) begin
      if (k > 1) @(negedge clk_in);
      chk("t2_gate", clk_gate_en_o, (k <= DRAIN + SETTLE + 1) ? 0 : 1);
      chk("t2_div", div_conf_o, (k >= DRAIN + 2) ? 3 : 1);
      chk("t2_rsp_valid", rsp_valid_o, (k == DRAIN + SETTLE + 2) ? 1 : 0);
      chk("t2_ready", req_ready_o, 0);
      chk("t2_busy", busy_o, 1);
    end
    collect_rsp(0);

    // Test 3: ratio 0 is rejected immediately without gating
    accept(2'd0);
    chk("t3_rsp_valid", rsp_valid_o, 1);
    chk("t3_rsp_err", rsp_err_o, 1);
    chk("t3_gate", clk_gate_en_o, 1);
    chk("t3_div", div_conf_o, 3);
    collect_rsp(0);

    // Test 4: ratio equal to current is a no-op success
    accept(2'd3);
    chk("t4_rsp_valid", rsp_valid_o, 1);
    chk("t4_rsp_err", rsp_err_o, 0);
    chk("t4_gate", clk_gate_en_o, 1);
    collect_rsp(0);

    // Test 5: change 3 -> 1 with a stalled response consumer
    accept(2'd1);
    collect_rsp(5);

    // Test 6: reset during SETTLE drops the request
    accept(2'd2);
    repeat (DRAIN + 3) @(negedge clk_in);
    chk("t6_div_applied", div_conf_o, 2);
    chk("t6_gate_low", clk_gate_en_o, 0);
    chk("t6_busy", busy_o, 1);
    rst = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    void'(exp_q.pop_back());
    model_div = 2'd1;
    chk("t6_div", div_conf_o, 1);
    chk("t6_gate", clk_gate_en_o, 1);
    chk("t6_rsp_valid", rsp_valid_o, 0);
    chk("t6_busy_idle", busy_o, 0);
    chk("t6_ready", req_ready_o, 1);
    repeat (3) @(negedge clk_in);
    chk("t6_no_rsp", rsp_valid_o, 0);

    // Controller still operates after the mid-flight reset
    accept(2'd2);
    collect_rsp(1);
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_clk_div_reconfig_ctrl
`default_nettype wire
